matrix_addsub_engine: RTL and testbench

Parametrised row-streaming matrix element-wise unit, successor to the fixed 4x4, 32-bit Adder ALU in the matrix math path. It takes an N x N signed matrix pair one row per accepted beat and returns one result row per beat. Supported operations are add, subtract and absolute difference, with selectable wrap or saturate overflow handling. Its Start/Done/Error contract lets the CPU-side sequencer stream rows from memory with backpressure instead of presenting whole matrices at once.

---
 rtl/matrix_pkg.sv | 26 ++
 rtl/matrix_lane.sv | 60 ++++++
 rtl/matrix_addsub_engine.sv | 148 ++++++++++++++
 tb/tb_matrix_addsub_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix add/sub engine.
//   - Opcode constants for add, subtract and absolute difference
//   - Engine state enum (IDLE / RUN / ERR)
//   - op_is_valid(): opcode legality check used when Start is sampled
package matrix_pkg;

    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_ABSDIFF = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        ERR  = 2'b10
    } state_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        logic valid;
        case (op)
            OP_ADD, OP_SUB, OP_ABSDIFF: valid = 1'b1;
            default:                    valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/matrix_lane.sv
// One element lane of the matrix engine: purely combinational.
//   op       in  opcode (latched by the top level)
//   a, b     in  signed WIDTH-bit operands
//   result   out WIDTH-bit result (wrapped or clamped)
//   overflow out result did not fit the signed WIDTH-bit range
module matrix_lane
    import matrix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit SAT   = 1'b0
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam logic signed [WIDTH:0] MAX_V = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0] MIN_V = {2'b11, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0] a_ext_s;
    logic signed [WIDTH:0] b_ext_s;
    logic signed [WIDTH:0] diff_s;
    logic signed [WIDTH:0] full_s;
    logic                  over_pos_s;
    logic                  over_neg_s;

    assign a_ext_s = {a[WIDTH-1], a};
    assign b_ext_s = {b[WIDTH-1], b};
    assign diff_s  = a_ext_s - b_ext_s;

    // Exact result in WIDTH+1 bits; |A-B| always fits there.
    always_comb begin
        full_s = {(WIDTH+1){1'b0}};
        case (op)
            OP_ADD:     full_s = a_ext_s + b_ext_s;
            OP_SUB:     full_s = diff_s;
            OP_ABSDIFF: full_s = diff_s[WIDTH] ? -diff_s : diff_s;
            default:    full_s = {(WIDTH+1){1'b0}};
        endcase
    end

    assign over_pos_s = (full_s > MAX_V);
    assign over_neg_s = (full_s < MIN_V);
    assign overflow   = over_pos_s | over_neg_s;

    // Wrapping a magnitude into a negative number is meaningless, so
    // ABSDIFF always clamps at the positive bound, independent of SAT.
    always_comb begin
        if (over_pos_s && (SAT || (op == OP_ABSDIFF))) begin
            result = MAX_V[WIDTH-1:0];
        end else if (over_neg_s && SAT) begin
            result = MIN_V[WIDTH-1:0];
        end else begin
            result = full_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/matrix_addsub_engine.sv
// Row-streaming N x N element-wise add / sub / absdiff engine.
//   Clock, ClearAll (sync active-high reset)
//   Start, Operation       : begin an operation (sampled in IDLE)
//   RowValid, RowA, RowB   : input row stream, accepted when RowReady
//   RowReady               : high while in RUN
//   ResultRow, ResultValid : registered result row, one cycle after accept
//   Busy, Done, Error      : status; Error is sticky until next good Start
module matrix_addsub_engine
    import matrix_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic               Clock,
    input  logic               ClearAll,
    input  logic               Start,
    input  logic [2:0]         Operation,
    input  logic               RowValid,
    input  logic [N*WIDTH-1:0] RowA,
    input  logic [N*WIDTH-1:0] RowB,
    output logic               RowReady,
    output logic [N*WIDTH-1:0] ResultRow,
    output logic               ResultValid,
    output logic               Busy,
    output logic               Done,
    output logic               Error
);

    localparam int                CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [N*WIDTH-1:0] result_row_q, result_row_d;
    logic               result_valid_q, result_valid_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [N*WIDTH-1:0] lane_row_s;
    logic [N-1:0]       lane_ovf_s;
    logic               accept_s;
    logic               last_s;

    for (genvar j = 0; j < N; j++) begin : g_lane
        matrix_lane #(
            .WIDTH (WIDTH),
            .SAT   (SAT)
        ) u_lane (
            .op       (op_q),
            .a        (RowA[j*WIDTH +: WIDTH]),
            .b        (RowB[j*WIDTH +: WIDTH]),
            .result   (lane_row_s[j*WIDTH +: WIDTH]),
            .overflow (lane_ovf_s[j])
        );
    end

    assign accept_s = RowValid & (state_q == RUN);
    assign last_s   = accept_s & (cnt_q == LAST_ROW);

    // State register.
    always_ff @(posedge Clock) begin
        if (ClearAll) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = op_is_valid(Operation) ? RUN : ERR;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output register next values.
    always_comb begin
        cnt_d          = cnt_q;
        op_d           = op_q;
        result_row_d   = result_row_q;
        result_valid_d = 1'b0;
        done_d         = 1'b0;
        error_d        = error_q;
        if ((state_q == IDLE) && Start) begin
            if (op_is_valid(Operation)) begin
                op_d    = Operation;
                cnt_d   = {CNT_W{1'b0}};
                error_d = 1'b0;
            end else begin
                error_d = 1'b1;
                done_d  = 1'b1;
            end
        end else if (accept_s) begin
            result_row_d   = lane_row_s;
            result_valid_d = 1'b1;
            error_d        = error_q | (|lane_ovf_s);
            done_d         = last_s;
            cnt_d          = last_s ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
        end else begin
            result_valid_d = 1'b0;
        end
    end

    // Datapath / output registers.
    always_ff @(posedge Clock) begin
        if (ClearAll) begin
            cnt_q          <= {CNT_W{1'b0}};
            op_q           <= 3'b000;
            result_row_q   <= {(N*WIDTH){1'b0}};
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            result_row_q   <= result_row_d;
            result_valid_q <= result_valid_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign RowReady    = (state_q == RUN);
    assign Busy        = (state_q != IDLE);
    assign ResultRow   = result_row_q;
    assign ResultValid = result_valid_q;
    assign Done        = done_q;
    assign Error       = error_q;

endmodule

// File: tb/tb_matrix_addsub_engine.sv
// Self-checking bench: a wrapping and a saturating engine share one input
// stream; expectations come from a signed-integer model of each element.
module tb_matrix_addsub_engine;

    localparam int N = 4;
    localparam int W = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic           Clock = 1'b0;
    logic           ClearAll, Start, RowValid;
    logic [2:0]     Operation;
    logic [N*W-1:0] RowA, RowB;

    logic           wr_ready, wr_valid, wr_busy, wr_done, wr_err;
    logic           st_ready, st_valid, st_busy, st_done, st_err;
    logic [N*W-1:0] wr_row, st_row;

    logic [N*W-1:0] ra [N];
    logic [N*W-1:0] rb [N];
    bit             err_exp;
    int             n_cmp = 0;
    int             n_bad = 0;

    always #5 Clock = ~Clock;

    matrix_addsub_engine #(.WIDTH(W), .N(N), .SAT(1'b0)) dut_wrap (
        .Clock(Clock), .ClearAll(ClearAll), .Start(Start), .Operation(Operation),
        .RowValid(RowValid), .RowA(RowA), .RowB(RowB), .RowReady(wr_ready),
        .ResultRow(wr_row), .ResultValid(wr_valid), .Busy(wr_busy),
        .Done(wr_done), .Error(wr_err));

    matrix_addsub_engine #(.WIDTH(W), .N(N), .SAT(1'b1)) dut_sat (
        .Clock(Clock), .ClearAll(ClearAll), .Start(Start), .Operation(Operation),
        .RowValid(RowValid), .RowA(RowA), .RowB(RowB), .RowReady(st_ready),
        .ResultRow(st_row), .ResultValid(st_valid), .Busy(st_busy),
        .Done(st_done), .Error(st_err));

    task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic bit valid_op(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b011) || (op == 3'b100);
    endfunction

    // Reference: exact signed arithmetic, then wrap or clamp.
    function automatic void ref_row(input logic [2:0] op, input logic [N*W-1:0] a,
                                    input logic [N*W-1:0] b, input bit sat,
                                    output logic [N*W-1:0] r, output bit ovf);
        longint x, y, v;
        logic [63:0] vb;
        ovf = 1'b0;
        r   = '0;
        for (int j = 0; j < N; j++) begin
            x = longint'($signed(a[j*W +: W]));
            y = longint'($signed(b[j*W +: W]));
            if (op == 3'b010)      v = x + y;
            else if (op == 3'b011) v = x - y;
            else                   v = (x - y < 0) ? y - x : x - y;
            vb = v;
            if (v > MAXV) begin
                ovf = 1'b1;
                r[j*W +: W] = (sat || op == 3'b100) ? 32'h7FFFFFFF : vb[31:0];
            end else if (v < MINV) begin
                ovf = 1'b1;
                r[j*W +: W] = sat ? 32'h80000000 : vb[31:0];
            end else begin
                r[j*W +: W] = vb[31:0];
            end
        end
    endfunction

    task automatic check_both(input string tag, input logic w, input logic s, input logic exp);
        check({tag, "_wrap"}, w, exp);
        check({tag, "_sat"}, s, exp);
    endtask

    task automatic do_start(input logic [2:0] op);
        Start = 1'b1;
        Operation = op;
        tick();
        Start = 1'b0;
        if (valid_op(op)) begin
            err_exp = 1'b0;
            check_both("start_busy", wr_busy, st_busy, 1'b1);
            check_both("start_ready", wr_ready, st_ready, 1'b1);
            check_both("start_err", wr_err, st_err, 1'b0);
            check_both("start_done", wr_done, st_done, 1'b0);
        end else begin
            err_exp = 1'b1;
            check_both("inv_err", wr_err, st_err, 1'b1);
            check_both("inv_done", wr_done, st_done, 1'b1);
            check_both("inv_busy", wr_busy, st_busy, 1'b1);
            check_both("inv_ready", wr_ready, st_ready, 1'b0);
            tick();
            check_both("inv_idle_busy", wr_busy, st_busy, 1'b0);
            check_both("inv_idle_ready", wr_ready, st_ready, 1'b0);
            check_both("inv_idle_done", wr_done, st_done, 1'b0);
            check_both("inv_idle_err", wr_err, st_err, 1'b1);
        end
    endtask

    // Stream all N rows of ra/rb; optional gap after one row and optional
    // Start/Operation disturbance while the run is in progress.
    task automatic send_rows(input logic [2:0] op, input int gap_row, input int gap_len,
                             input bit disturb);
        logic [N*W-1:0] exp_w, exp_s;
        bit ovf_w, ovf_s;
        for (int r = 0; r < N; r++) begin
            RowA = ra[r];
            RowB = rb[r];
            RowValid = 1'b1;
            if (disturb) begin
                Start = 1'b1;
                Operation = op ^ 3'b001;
            end
            tick();
            ref_row(op, ra[r], rb[r], 1'b0, exp_w, ovf_w);
            ref_row(op, ra[r], rb[r], 1'b1, exp_s, ovf_s);
            err_exp = err_exp | ovf_w;
            check("row_wrap", wr_row, exp_w);
            check("row_sat", st_row, exp_s);
            check_both("row_valid", wr_valid, st_valid, 1'b1);
            check_both("row_done", wr_done, st_done, r == N - 1);
            check_both("row_busy", wr_busy, st_busy, r != N - 1);
            check_both("row_ready", wr_ready, st_ready, r != N - 1);
            check_both("row_err", wr_err, st_err, err_exp);
            RowValid = 1'b0;
            Start = 1'b0;
            if (r == gap_row) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    check_both("gap_valid", wr_valid, st_valid, 1'b0);
                    check_both("gap_done", wr_done, st_done, 1'b0);
                    check_both("gap_ready", wr_ready, st_ready, 1'b1);
                end
            end
        end
        tick();
        check_both("post_valid", wr_valid, st_valid, 1'b0);
        check_both("post_done", wr_done, st_done, 1'b0);
        check_both("post_busy", wr_busy, st_busy, 1'b0);
        check_both("post_err", wr_err, st_err, err_exp);
    endtask

    task automatic fill_const(input logic [31:0] a, input logic [31:0] b);
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) begin
                ra[r][j*W +: W] = a;
                rb[r][j*W +: W] = b;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [2:0] op;
        ClearAll = 1'b1;
        Start = 1'b0;
        RowValid = 1'b0;
        Operation = 3'b000;
        RowA = '0;
        RowB = '0;
        err_exp = 1'b0;
        repeat (2) tick();
        check("rst_row", wr_row, '0);
        check_both("rst_ready", wr_ready, st_ready, 1'b0);
        check_both("rst_valid", wr_valid, st_valid, 1'b0);
        check_both("rst_busy", wr_busy, st_busy, 1'b0);
        check_both("rst_done", wr_done, st_done, 1'b0);
        check_both("rst_err", wr_err, st_err, 1'b0);
        ClearAll = 1'b0;
        tick();

        // ADD -4 + 10, back-to-back rows.
        fill_const(32'hFFFFFFFC, 32'd10);
        do_start(3'b010);
        send_rows(3'b010, -1, 0, 1'b0);
        check("add_six", wr_row[31:0], 32'd6);

        // SUB 5 - 9 with a 2-cycle gap between rows 1 and 2.
        fill_const(32'd5, 32'd9);
        do_start(3'b011);
        send_rows(3'b011, 1, 2, 1'b0);
        check("sub_m4", st_row[31:0], 32'hFFFFFFFC);

        // Positive overflow on row 0 element 0.
        fill_const(32'd0, 32'd0);
        ra[0][31:0] = 32'h7FFFFFFF;
        rb[0][31:0] = 32'd1;
        do_start(3'b010);
        send_rows(3'b010, -1, 0, 1'b0);

        // ABSDIFF at the positive bound.
        fill_const(32'd0, 32'd0);
        ra[0][31:0] = 32'h80000000;
        do_start(3'b100);
        send_rows(3'b100, -1, 0, 1'b0);

        // Invalid opcode, then a good Start clears Error.
        do_start(3'b111);
        fill_const(32'd3, 32'd1);
        do_start(3'b010);
        send_rows(3'b010, -1, 0, 1'b0);

        // ClearAll after two accepted rows, asserted together with Start/RowValid.
        do_start(3'b010);
        for (int r = 0; r < 2; r++) begin
            RowA = ra[r];
            RowB = rb[r];
            RowValid = 1'b1;
            tick();
            check_both("abort_row_valid", wr_valid, st_valid, 1'b1);
        end
        ClearAll = 1'b1;
        Start = 1'b1;
        tick();
        check("abort_row", wr_row, '0);
        check_both("abort_ready", wr_ready, st_ready, 1'b0);
        check_both("abort_valid", wr_valid, st_valid, 1'b0);
        check_both("abort_busy", wr_busy, st_busy, 1'b0);
        check_both("abort_done", wr_done, st_done, 1'b0);
        check_both("abort_err", wr_err, st_err, 1'b0);
        ClearAll = 1'b0;
        Start = 1'b0;
        RowValid = 1'b0;
        tick();
        check_both("abort_idle_done", wr_done, st_done, 1'b0);
        check_both("abort_idle_busy", wr_busy, st_busy, 1'b0);

        // Start pulsed and Operation changed while busy: ignored.
        fill_const(32'd20, 32'd7);
        do_start(3'b011);
        send_rows(3'b011, 1, 1, 1'b1);

        // Randomized operations, operands and gaps.
        for (int t = 0; t < 12; t++) begin
            op = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 4));
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) begin
                    ra[r][j*W +: W] = pick();
                    rb[r][j*W +: W] = pick();
                end
            end
            do_start(op);
            if (valid_op(op)) begin
                send_rows(op, $urandom_range(0, N - 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
